imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the CPU instruction memory; the fetch stage is the only reader of that memory.
- Accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words to sequential instruction-memory word addresses starting at 0, then checks an XOR checksum.
- Holds the CPU in reset until a load completes with a good checksum.

Parameters:
- DEPTH, 32, number of instruction-memory words (legal length range 1..DEPTH).
- ADDR_W, 5, word-address width, equal to clog2(DEPTH).

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous active-low reset
- in_valid  input  1  stream byte valid
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  word address of the write
- mem_wdata  output  32  assembled instruction word
- cpu_rst  output  1  active-low reset to the CPU; high only in DONE
- done  output  1  load completed, checksum good
- error  output  1  load failed (bad length or bad checksum)
- words_loaded  output  ADDR_W+1  count of words written in the current load

Behaviour:
- Frame format: 0xA5 sync, then LEN (word count), then 4*LEN data bytes (LSB first per word), then CSUM = XOR of all data bytes.
- A byte is accepted on a rising edge where in_valid && in_ready.
- States and transitions:
  - IDLE: discard bytes until 0xA5 is accepted, then go to LEN.
  - LEN: accept one byte. If it is 0 or >DEPTH, go to ERROR. Otherwise latch LEN, clear the word counter, byte index and checksum, and go to DATA.
  - DATA: for byte index b = 0..3, place the byte in word bits [8b+7:8b] and XOR it into the checksum. When the 4th byte is accepted, go to WRITE.
  - WRITE: one cycle.
    - mem_we=1, mem_addr = word counter, mem_wdata = assembled word; in_ready=0.
    - On exit, increment the word counter and words_loaded.
    - Go to CSUM if the counter reaches LEN, else back to DATA.
  - CSUM: accept one byte. If it equals the running checksum, go to DONE, else go to ERROR.
  - DONE: cpu_rst=1, done=1. Accepting 0xA5 restarts the load: go to LEN, clear done, drive cpu_rst=0 from the next cycle.
  - ERROR: error=1, cpu_rst=0. Accepting 0xA5 clears error and goes to LEN. Other bytes are discarded.
- in_ready:
  - 1 in IDLE, LEN, DATA, CSUM, DONE and ERROR; 0 in WRITE.
  - Forced to 0 while rst=0.
  - A byte held valid during WRITE is not lost; it is accepted in the next cycle.
- Output timing: all outputs except in_ready are registered and take their new value the cycle after the accepting edge or state change.
- Data writes are not rolled back on a checksum failure. The memory contents are then undefined for use, and the CPU stays in reset.
- Reset (rst=0 at a rising edge), including mid-load:
  - state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rst=0, done=0, error=0, words_loaded=0.
  - Checksum, byte index and partial word are cleared.
- Widths:
  - The word counter is ADDR_W+1 bits so that LEN=DEPTH is representable.
  - mem_addr is the low ADDR_W bits of the counter and never wraps within a legal load.

Test Plan:
- Good load, bytes A5 02 00 00 00 00 13 01 50 00 42 with in_valid held high:
  - mem_we pulses twice: addr0=0x00000000, then addr1=0x00500113.
  - Final state: done=1, cpu_rst=1, error=0, words_loaded=2.
- Bad checksum, same frame ending in 0x43:
  - Both writes still occur.
  - Final state: error=1, done=0, cpu_rst=0.
- Length bounds:
  - LEN=0x00 -> error=1 the cycle after the LEN byte, no mem_we.
  - LEN=0x21 with DEPTH=32 -> same response.
  - LEN=0x20 -> 32 writes, addresses 0..31.
- Leading noise then good frame: 00 FF 13 before A5 01 93 00 A1 00 32 -> single write addr0=0x00A10093, done=1.
  - Check: CSUM 0x32 = 0x93^0x00^0xA1^0x00.
- Backpressure: in_valid held high with the first byte of word 1 present during WRITE of word 0 -> in_ready=0 that cycle; byte accepted the next cycle; word 1 intact.
- Reset and restart:
  - rst=0 after 5 data bytes -> all outputs at reset values the next cycle; a fresh full frame then completes normally.
  - From DONE, sending A5 -> cpu_rst=0 and done=0 the next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write bus of the boot loader
// Signals:
//   in_valid, in_data, in_ready : valid/ready byte stream into the loader
//   mem_we, mem_addr, mem_wdata : single-cycle word write strobe, word address, word data
// Modports: slave = loader side, master = stream source / memory side
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer fed by a framed, checksummed byte stream
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   bus          : imem_loader_if.slave (byte stream in, memory word writes out)
//   cpu_rst      : active-low CPU reset, released only after a good load
//   done         : load completed with good checksum
//   error        : load failed (bad length or bad checksum)
//   words_loaded : words written in the current load
// Frame: A5, LEN, 4*LEN data bytes (little-endian words), XOR of all data bytes.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int CW = ADDR_W + 1;
    localparam logic [7:0] SYNC = 8'hA5;
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;
    state_t state, state_nx;
    logic [CW-1:0] len, cnt;
    logic [1:0]    bidx;
    logic [31:0]   word;
    logic [7:0]    csum;
    logic          acc, len_ok, last;
    assign bus.in_ready = rst && state != WRITE;
    assign acc          = bus.in_valid && bus.in_ready;
    assign len_ok       = bus.in_data != 8'd0 && bus.in_data <= 8'(DEPTH);
    assign last         = cnt + CW'(1) == len;
    // Word counter and assembly register are already registered, so they drive the bus directly.
    assign bus.mem_addr  = cnt[ADDR_W-1:0];
    assign bus.mem_wdata = word;
    assign words_loaded  = cnt;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (acc && bus.in_data == SYNC) state_nx = LEN;
            LEN:         if (acc) state_nx = len_ok ? DATA : ERROR;
            DATA:        if (acc && bidx == 2'd3) state_nx = WRITE;
            WRITE:       state_nx = last ? CSUM : DATA;
            CSUM:        if (acc) state_nx = bus.in_data == csum ? DONE : ERROR;
            DONE, ERROR: if (acc && bus.in_data == SYNC) state_nx = LEN;
            default:     state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            len        <= '0;
            cnt        <= '0;
            bidx       <= '0;
            word       <= '0;
            csum       <= '0;
            bus.mem_we <= 1'b0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nx;
            bus.mem_we <= state_nx == WRITE;
            cpu_rst    <= state_nx == DONE;
            done       <= state_nx == DONE;
            error      <= state_nx == ERROR;
            if (state == LEN && acc && len_ok) begin
                len  <= CW'(bus.in_data);
                cnt  <= '0;
                bidx <= '0;
                csum <= '0;
            end
            if (state == DATA && acc) begin
                word[8*bidx +: 8] <= bus.in_data;
                csum              <= csum ^ bus.in_data;
                bidx              <= bidx + 2'd1;
            end
            if (state == WRITE) cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frame-level checks of imem_loader
module tb_imem_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_rst, done, error;
    logic [ADDR_W:0] words_loaded;
    int total = 0;
    int passed = 0;
    int exp_loaded = 0;
    int wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0] good_frame [11] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h42};
    logic [7:0] noise_frame [10] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h93, 8'h00, 8'hA1, 8'h00, 8'h32};

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(int'(bus.mem_addr));
            wr_data.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present a byte at a falling edge and return at the falling edge after it is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int n = 0; n < 8 && !bus.in_ready; n++) @(negedge clk);
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit ok, input bit bad, input int loaded);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(ok));
        check({tag, "_error"}, 32'(error), 32'(bad));
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(loaded));
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check_status(tag, 1'b0, 1'b0, 0);
        rst = 1'b1;
        exp_loaded = 0;
        #1;
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Frame-level model: a legal length writes every word in order at 0..len-1;
    // the outcome depends only on whether the trailing checksum matches.
    task automatic run_frame(input int len, input bit bad, input int noise, input int gapmax);
        logic [31:0] words[$];
        logic [7:0] cs, b;
        wr_addr.delete();
        wr_data.delete();
        repeat (noise) begin
            do b = 8'($urandom); while (b == 8'hA5);
            send(b, $urandom_range(0, gapmax));
        end
        send(8'hA5, $urandom_range(0, gapmax));
        send(8'(len), $urandom_range(0, gapmax));
        if (len < 1 || len > DEPTH) begin
            check("badlen_writes", 32'(wr_addr.size()), 32'd0);
            check_status("badlen", 1'b0, 1'b1, exp_loaded);
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < len; w++) begin
            words.push_back($urandom);
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                cs ^= b;
                send(b, $urandom_range(0, gapmax));
            end
        end
        send(bad ? cs ^ 8'(1 << $urandom_range(0, 7)) : cs, $urandom_range(0, gapmax));
        exp_loaded = len;
        check("frame_write_count", 32'(wr_addr.size()), 32'(len));
        for (int w = 0; w < len && w < wr_addr.size(); w++) begin
            check("frame_addr", 32'(wr_addr[w]), 32'(w));
            check("frame_data", wr_data[w], words[w]);
        end
        check_status("frame", !bad, bad, len);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        do_reset("reset");

        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < 6; i++) send(good_frame[i], 0);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_mem_we", 32'(bus.mem_we), 32'd1);
        check("bp_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("bp_mem_wdata", bus.mem_wdata, 32'h0000_0000);
        for (int i = 6; i < 11; i++) send(good_frame[i], 0);
        check("good_write_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("good_addr0", 32'(wr_addr[0]), 32'd0);
            check("good_data0", wr_data[0], 32'h0000_0000);
            check("good_addr1", 32'(wr_addr[1]), 32'd1);
            check("good_data1", wr_data[1], 32'h0050_0113);
        end
        check_status("good", 1'b1, 1'b0, 2);

        wr_addr.delete();
        wr_data.delete();
        send(8'hA5, 0);
        check("restart_cpu_rst", 32'(cpu_rst), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        for (int i = 1; i < 10; i++) send(good_frame[i], 0);
        send(8'h43, 0);
        check("badcs_write_count", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) check("badcs_data1", wr_data[1], 32'h0050_0113);
        check_status("badcs", 1'b0, 1'b1, 2);
        exp_loaded = 2;

        wr_addr.delete();
        send(8'hA5, 0);
        check("err_clear", 32'(error), 32'd0);
        send(8'h00, 0);
        check("len0_error", 32'(error), 32'd1);
        check("len0_mem_we", 32'(bus.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        check("len0_writes", 32'(wr_addr.size()), 32'd0);
        run_frame(33, 1'b0, 0, 0);
        run_frame(32, 1'b0, 0, 0);

        do_reset("reset2");
        wr_addr.delete();
        wr_data.delete();
        foreach (noise_frame[i]) send(noise_frame[i], 0);
        check("noise_write_count", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("noise_addr0", 32'(wr_addr[0]), 32'd0);
            check("noise_data0", wr_data[0], 32'h00A1_0093);
        end
        check_status("noise", 1'b1, 1'b0, 1);
        exp_loaded = 1;

        send(8'hA5, 0);
        send(8'h03, 0);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(1, 255)), 0);
        do_reset("midload");
        run_frame($urandom_range(1, DEPTH), 1'b0, 0, 1);

        for (int f = 0; f < 20; f++) begin
            int len;
            if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1) ? 0 : $urandom_range(DEPTH + 1, 255);
            else len = $urandom_range(1, DEPTH);
            run_frame(len, $urandom_range(0, 3) == 0, $urandom_range(0, 3), 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
